// File: rtl/uart_tx_scheduler_pkg.sv
// Frame format constants and FSM state encoding shared by the UART TX scheduler.
package uart_frame_pkg;

  // Start-of-frame marker the receiver resynchronises on
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Bytes added around the payload: header, source id, checksum
  localparam int unsigned FRAME_OVERHEAD = 3;

  // Scheduler states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake plus TX FIFO write port of the UART TX scheduler.
interface uart_tx_scheduler_if #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned FRAME_LEN = 4
) ();

  logic [NREQ-1:0]             req;
  logic [NREQ*FRAME_LEN*8-1:0] frame_data;
  logic [NREQ-1:0]             ack;
  logic                        tx_full;
  logic                        wr_uart;
  logic [7:0]                  w_data;
  logic                        busy;

  // Scheduler side
  modport master (
    input  req,
    input  frame_data,
    input  tx_full,
    output ack,
    output wr_uart,
    output w_data,
    output busy
  );

  // Requesters and TX FIFO side
  modport slave (
    output req,
    output frame_data,
    output tx_full,
    input  ack,
    input  wr_uart,
    input  w_data,
    input  busy
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [7:0]      last_grant_i,
  output logic [7:0]      grant_o,
  output logic            any_req_o
);

  logic found;

  assign any_req_o = |req_i;

  // Two passes: indices above last_grant first, then wrap around from index 0
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (8'(i) > last_grant_i)) begin
        grant_o = 8'(i);
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o = 8'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler serialising requester frames (header, id, payload, XOR checksum)
// into the UART TX FIFO write port.
module uart_tx_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [7:0]  HDR_BYTE  = uart_frame_pkg::HDR_BYTE
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_scheduler_if.master  bus
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned FW    = FRAME_LEN * 8;

  logic [2:0]       state_q, state_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_grant_q, last_grant_d;
  logic [7:0]       gid_q, gid_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic [7:0] grant;
  logic       any_req;
  logic       wr;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i        (bus.req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_req_o    (any_req)
  );

  // Write whenever a frame is in flight and the FIFO has room
  assign wr          = (state_q != ST_IDLE) && !bus.tx_full;
  assign bus.wr_uart = wr;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.ack     = ack_q;

  // Output byte selected from registered state, so it holds steady while stalled
  always_comb begin
    case (state_q)
      ST_HDR:  bus.w_data = HDR_BYTE;
      ST_ID:   bus.w_data = gid_q;
      ST_PAY:  bus.w_data = frame_q[7:0];
      ST_CSUM: bus.w_data = csum_q;
      default: bus.w_data = '0;
    endcase
  end

  // Next-state logic: grant in IDLE, then advance one byte per accepted write
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    ack_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == 8'(i)) begin
              frame_d  = bus.frame_data[i*FW +: FW];
              ack_d[i] = 1'b1;
            end
          end
          last_grant_d = grant;
          gid_d        = grant;
          csum_d       = grant;
          cnt_d        = '0;
          state_d      = ST_HDR;
        end
      end
      ST_HDR: begin
        if (wr) state_d = ST_ID;
      end
      ST_ID: begin
        if (wr) state_d = ST_PAY;
      end
      ST_PAY: begin
        // Frame register shifts down so the current payload byte is always bits [7:0]
        if (wr) begin
          csum_d  = csum_q ^ frame_q[7:0];
          frame_d = frame_q >> 8;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      csum_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= 8'(NREQ - 1);
      gid_q        <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      ack_q        <= ack_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with NREQ=2, FRAME_LEN=4.
module tb_uart_tx_scheduler;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  uart_tx_scheduler_if #(.NREQ(2), .FRAME_LEN(4)) bus ();

  uart_tx_scheduler #(
    .NREQ      (2),
    .FRAME_LEN (4),
    .HDR_BYTE  (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       req;
    logic [63:0]      fd;
    logic [1:0]       ack;
    logic [0:6][7:0]  bytes;
  } vec_t;

  vec_t vec [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Checks one write at the current negedge, then moves to the next negedge
  task automatic expect_write(input string nm, input logic [7:0] b);
    check({nm, " wr_uart"}, 64'(bus.wr_uart), 64'd1);
    check({nm, " w_data"}, 64'(bus.w_data), 64'(b));
    @(negedge clk);
  endtask

  // Issue a request, check the ack cycle and the full unstalled frame
  task automatic run_frame(input string nm, input logic [1:0] rq, input logic [63:0] fd,
                           input logic [1:0] exp_ack, input logic [0:6][7:0] bytes);
    bus.req        = rq;
    bus.frame_data = fd;
    @(negedge clk);
    check({nm, " ack"}, 64'(bus.ack), 64'(exp_ack));
    check({nm, " busy"}, 64'(bus.busy), 64'd1);
    bus.req        = 2'b00;
    bus.frame_data = ~fd;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) check({nm, " ack one cycle"}, 64'(bus.ack), 64'd0);
      expect_write($sformatf("%s byte%0d", nm, k), bytes[k]);
    end
    check({nm, " idle busy"}, 64'(bus.busy), 64'd0);
    check({nm, " idle wr_uart"}, 64'(bus.wr_uart), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    vec[0] = '{2'b01, {32'h0, 32'h44332211}, 2'b01,
               {8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}};
    vec[1] = '{2'b11, {32'h40302010, 32'h04030201}, 2'b10,
               {8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h41}};
    vec[2] = '{2'b11, {32'h40302010, 32'h04030201}, 2'b01,
               {8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}};
    vec[3] = '{2'b11, {32'h40302010, 32'h04030201}, 2'b10,
               {8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h41}};
    vec[4] = '{2'b10, {32'h00FF55AA, 32'h0}, 2'b10,
               {8'hA5, 8'h01, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h01}};
    vec[5] = '{2'b01, {32'h0, 32'hC37E0180}, 2'b01,
               {8'hA5, 8'h00, 8'h80, 8'h01, 8'h7E, 8'hC3, 8'h3C}};

    reset          = 1'b0;
    bus.req        = 2'b00;
    bus.frame_data = '0;
    bus.tx_full    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ack", 64'(bus.ack), 64'd0);
    check("reset wr_uart", 64'(bus.wr_uart), 64'd0);
    check("reset w_data", 64'(bus.w_data), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle no req", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vec[i].req, vec[i].fd, vec[i].ack, vec[i].bytes);

    // Backpressure during the PAY write of byte 33
    bus.req        = 2'b01;
    bus.frame_data = {32'h0, 32'h44332211};
    @(negedge clk);
    check("bp ack", 64'(bus.ack), 64'd1);
    bus.req = 2'b00;
    expect_write("bp hdr", 8'hA5);
    expect_write("bp id", 8'h00);
    expect_write("bp b0", 8'h11);
    expect_write("bp b1", 8'h22);
    bus.tx_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp stall wr_uart", 64'(bus.wr_uart), 64'd0);
      check("bp stall w_data", 64'(bus.w_data), 64'h33);
      @(negedge clk);
    end
    bus.tx_full = 1'b0;
    #1;
    expect_write("bp b2", 8'h33);
    expect_write("bp b3", 8'h44);
    expect_write("bp csum", 8'h44);
    check("bp idle", 64'(bus.busy), 64'd0);

    // Stall on header: FIFO full before the request
    bus.tx_full    = 1'b1;
    bus.req        = 2'b10;
    bus.frame_data = {32'h04030201, 32'h0};
    @(negedge clk);
    check("hs ack", 64'(bus.ack), 64'd2);
    bus.req = 2'b00;
    for (int s = 0; s < 10; s++) begin
      check("hs stall wr_uart", 64'(bus.wr_uart), 64'd0);
      check("hs stall w_data", 64'(bus.w_data), 64'hA5);
      @(negedge clk);
    end
    bus.tx_full = 1'b0;
    #1;
    expect_write("hs hdr", 8'hA5);
    expect_write("hs id", 8'h01);
    expect_write("hs b0", 8'h01);
    expect_write("hs b1", 8'h02);
    expect_write("hs b2", 8'h03);
    expect_write("hs b3", 8'h04);
    expect_write("hs csum", 8'h05);
    check("hs idle", 64'(bus.busy), 64'd0);

    // Reset mid-frame after two payload bytes
    bus.req        = 2'b01;
    bus.frame_data = {32'h0, 32'h44332211};
    @(negedge clk);
    check("rst ack", 64'(bus.ack), 64'd1);
    bus.req = 2'b00;
    expect_write("rst hdr", 8'hA5);
    expect_write("rst id", 8'h00);
    expect_write("rst b0", 8'h11);
    expect_write("rst b1", 8'h22);
    reset = 1'b0;
    #1;
    check("rst wr_uart", 64'(bus.wr_uart), 64'd0);
    check("rst ack low", 64'(bus.ack), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame("post rst req1", 2'b10, {32'h40302010, 32'h0}, 2'b10,
              {8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h41});

    // Pointer returns to NREQ-1 on reset: after granting 0, reset makes 0 first again
    run_frame("pre rst2", 2'b01, {32'h0, 32'h44332211}, 2'b01,
              {8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame("post rst2 both", 2'b11, {32'h40302010, 32'h04030201}, 2'b01,
              {8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
